// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared types and helpers for the GPIO write arbiter.
//   state_t  - arbiter FSM states (IDLE / ISSUE / LOCKED)
//   owner_w  - width of a requester index for a given requester count
package gpio_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, LOCKED} state_t;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_rr_pick.sv
// gpio_rr_pick: combinational round-robin pick starting at i_ptr.
//   i_req   - request vector
//   i_ptr   - index with highest priority this cycle
//   o_valid - at least one request present
//   o_idx   - winning requester index
module gpio_rr_pick
    import gpio_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int OW = owner_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [OW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [OW-1:0]   o_idx
);

    logic [NREQ-1:0] w_rot;
    logic [OW-1:0]   w_off;
    logic [OW:0]     w_sum;

    // Rotate so i_ptr lands at bit 0, take the lowest set bit, then rotate the
    // offset back by adding i_ptr modulo NREQ.
    always_comb begin
        w_rot = NREQ'({i_req, i_req} >> i_ptr);
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (w_rot[k]) w_off = OW'(k);
        w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
        o_idx   = (w_sum >= (OW+1)'(NREQ)) ? OW'(w_sum - (OW+1)'(NREQ)) : w_sum[OW-1:0];
        o_valid = |i_req;
    end

endmodule

// File: rtl/gpio_write_arbiter.sv
// gpio_write_arbiter: round-robin sharing of the GPIO write port with lockable ownership.
//   clk, rst       - clock, asynchronous active-high reset
//   i_req          - per-core write request, held until acked
//   i_req_mask     - per-core pin mask, slice i = [i*WIDTH +: WIDTH]
//   i_req_data     - per-core write data, same slicing
//   i_req_lock     - keep exclusive ownership after grant
//   o_ack          - one-cycle pulse to the served core
//   o_gpio_dir     - GPIO dir (held while o_gpio_we is low)
//   o_gpio_wdata   - GPIO write_data (held while o_gpio_we is low)
//   o_gpio_we      - GPIO write_enable
//   o_owner        - last granted / locking requester
//   o_locked       - FSM is in LOCKED
module gpio_write_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    localparam int OW = owner_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*WIDTH-1:0] i_req_mask,
    input  logic [NREQ*WIDTH-1:0] i_req_data,
    input  logic [NREQ-1:0]       i_req_lock,
    output logic [NREQ-1:0]       o_ack,
    output logic [WIDTH-1:0]      o_gpio_dir,
    output logic [WIDTH-1:0]      o_gpio_wdata,
    output logic                  o_gpio_we,
    output logic [OW-1:0]         o_owner,
    output logic                  o_locked
);

    state_t           r_state;
    logic [OW-1:0]    r_ptr;
    logic [OW-1:0]    r_owner;
    logic             r_lock_pending;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_wdata;
    logic             r_we;
    logic [NREQ-1:0]  r_ack;

    logic             w_valid;
    logic [OW-1:0]    w_idx;
    logic [OW-1:0]    w_sel;
    logic             w_go;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_data;

    gpio_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // In LOCKED only the owner may be served; in IDLE the round-robin winner.
    assign w_sel  = (r_state == LOCKED) ? r_owner : w_idx;
    assign w_go   = (r_state == IDLE && w_valid) || (r_state == LOCKED && i_req[r_owner]);
    assign w_mask = i_req_mask[w_sel*WIDTH +: WIDTH];
    assign w_data = i_req_data[w_sel*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_owner        <= '0;
            r_lock_pending <= 1'b0;
            r_dir          <= '0;
            r_wdata        <= '0;
            r_we           <= 1'b0;
            r_ack          <= '0;
        end else begin
            r_we  <= 1'b0;
            r_ack <= '0;
            if (w_go) begin
                r_dir          <= w_mask;
                r_wdata        <= w_data;
                r_owner        <= w_sel;
                r_lock_pending <= i_req_lock[w_sel];
                r_we           <= 1'b1;
                r_ack          <= NREQ'(1) << w_sel;
                r_state        <= ISSUE;
            end else if (r_state == ISSUE) begin
                // Requests are not sampled here, so a core dropping req after ack is never re-served.
                r_ptr   <= (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                r_state <= r_lock_pending ? LOCKED : IDLE;
            end else if (r_state == LOCKED && !i_req_lock[r_owner]) begin
                r_state <= IDLE;
            end
        end
    end

    assign o_ack        = r_ack;
    assign o_gpio_dir   = r_dir;
    assign o_gpio_wdata = r_wdata;
    assign o_gpio_we    = r_we;
    assign o_owner      = r_owner;
    assign o_locked     = (r_state == LOCKED);

endmodule

// File: tb/tb_gpio_write_arbiter.sv
// tb_gpio_write_arbiter: directed table-driven bench for gpio_write_arbiter.
module tb_gpio_write_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [3:0]   lock = '0;
    logic [127:0] mask = '0;
    logic [127:0] data = '0;
    logic [3:0]   ack;
    logic [31:0]  dir;
    logic [31:0]  wdata;
    logic         we;
    logic [1:0]   owner;
    logic         locked;
    logic [31:0]  pins;
    int           n_cmp = 0;
    int           n_bad = 0;

    typedef struct {
        int          idx;
        logic [31:0] mask;
        logic [31:0] data;
        logic [3:0]  ack;
        logic [31:0] pins;
    } vec_t;
    vec_t vecs[4];

    int a_idx[8];
    int a_t[8];
    int na;

    gpio_write_arbiter #(.NREQ(4), .WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req),
        .i_req_mask   (mask),
        .i_req_data   (data),
        .i_req_lock   (lock),
        .o_ack        (ack),
        .o_gpio_dir   (dir),
        .o_gpio_wdata (wdata),
        .o_gpio_we    (we),
        .o_owner      (owner),
        .o_locked     (locked)
    );

    always #5 clk = ~clk;

    // GPIO output register model driven by the arbiter's write port.
    always @(posedge clk or posedge rst)
        if (rst) pins <= '0;
        else if (we) pins <= (pins & ~dir) | (wdata & dir);

    always @(negedge clk)
        if (!rst) begin
            n_cmp++;
            if (we !== |ack || !$onehot0(ack)) begin
                n_bad++;
                $display("FAIL we_ack: got we=%b ack=%b, required we==|ack with at most one ack bit", we, ack);
            end
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req  = '0;
        lock = '0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
    endtask

    task automatic set_slot(input int k, input logic [31:0] m, input logic [31:0] d);
        mask[k*32 +: 32] = m;
        data[k*32 +: 32] = d;
    endtask

    // Runs for a number of cycles, logging each ack; optionally drops a served request.
    task automatic collect(input int ticks, input logic drop);
        na = 0;
        for (int t = 1; t <= ticks; t++) begin
            tick();
            if (ack != 0 && na < 8) begin
                for (int b = 0; b < 4; b++)
                    if (ack[b]) a_idx[na] = b;
                a_t[na] = t;
                chk("collect_dir", dir, mask[a_idx[na]*32 +: 32]);
                chk("collect_wdata", wdata, data[a_idx[na]*32 +: 32]);
                na++;
                if (drop) req = req & ~ack;
            end
        end
    endtask

    initial begin
        logic [3:0] exp_ack_c[1:7];
        logic       exp_lck_c[1:7];
        logic       got;

        vecs[0] = '{2, 32'h0000_00FF, 32'h0000_00A5, 4'b0100, 32'h0000_00A5};
        vecs[1] = '{3, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000, 32'h0000_00A5};
        vecs[2] = '{0, 32'hFFFF_0000, 32'h1234_5678, 4'b0001, 32'h1234_00A5};
        vecs[3] = '{1, 32'hF0F0_F0F0, 32'hAAAA_5555, 4'b0010, 32'hA2A4_5055};

        #2;
        chk("rst_ack", ack, 0);
        chk("rst_we", we, 0);
        chk("rst_dir", dir, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_owner", owner, 0);
        chk("rst_locked", locked, 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            set_slot(vecs[i].idx, vecs[i].mask, vecs[i].data);
            req = 4'b0001 << vecs[i].idx;
            tick();
            chk("vec_we", we, 1);
            chk("vec_ack", ack, vecs[i].ack);
            chk("vec_dir", dir, vecs[i].mask);
            chk("vec_wdata", wdata, vecs[i].data);
            chk("vec_owner", owner, vecs[i].idx);
            req = '0;
            tick();
            chk("vec_we_off", we, 0);
            chk("vec_ack_off", ack, 0);
            chk("vec_dir_hold", dir, vecs[i].mask);
            chk("vec_pins", pins, vecs[i].pins);
        end

        do_reset();
        for (int k = 0; k < 4; k++) set_slot(k, 32'h0000_00FF << (8*k), 32'h1111_1111 * (k+1));
        req = 4'hF;
        collect(8, 1'b1);
        chk("all4_count", na, 4);
        for (int n = 0; n < 4; n++) begin
            chk("all4_order", a_idx[n], n);
            chk("all4_cycle", a_t[n], 2*n + 1);
        end
        req = 4'b1001;
        tick();
        chk("all4_ptr_wrap", ack, 4'b0001);
        req = '0;
        tick();

        do_reset();
        req = 4'b1010;
        collect(8, 1'b0);
        chk("alt_count", na, 4);
        for (int n = 0; n < 4; n++) begin
            chk("alt_order", a_idx[n], (n % 2 == 0) ? 1 : 3);
            chk("alt_cycle", a_t[n], 2*n + 1);
        end
        req = '0;
        tick();
        tick();

        do_reset();
        exp_ack_c = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        exp_lck_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        set_slot(0, 32'h0000_0001, 32'h0000_0001);
        set_slot(2, 32'h0000_0F00, 32'h0000_0500);
        lock = 4'b0001;
        req  = 4'b0101;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk("lock_ack", ack, exp_ack_c[t]);
            chk("lock_locked", locked, exp_lck_c[t]);
            if (t == 5) req[0] = 1'b0;
        end
        lock = '0;
        got = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            tick();
            if (ack == 4'b0100) got = 1'b1;
        end
        chk("lock_release_grant", got, 1);
        chk("lock_release_owner", owner, 2);
        req = '0;
        tick();

        do_reset();
        set_slot(1, 32'h0F0F_0000, 32'hDEAD_BEEF);
        req = 4'b0010;
        tick();
        chk("rstmid_we_before", we, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_we", we, 0);
        chk("rstmid_ack", ack, 0);
        chk("rstmid_dir", dir, 0);
        chk("rstmid_wdata", wdata, 0);
        chk("rstmid_owner", owner, 0);
        #1 rst = 1'b0;
        tick();
        chk("rstmid_reissue_ack", ack, 4'b0010);
        chk("rstmid_reissue_dir", dir, 32'h0F0F_0000);
        chk("rstmid_reissue_wdata", wdata, 32'hDEAD_BEEF);
        req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_write_arbiter.md
# gpio_write_arbiter

Shares the single write port of the GPIO output block among `NREQ` cores of the MPSoC. Each core posts a masked write (dir mask + data). The arbiter grants requesters round-robin and drives `dir`/`write_data`/`write_enable` of the GPIO for exactly one cycle per granted write. A requester can hold a lock for atomic multi-write sequences, such as bit-banged protocols.

## Interface
- `NREQ`, 4, number of requesting cores (2..8)
- `WIDTH`, 32, GPIO width; must match the GPIO block
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  NREQ  per-core write request; held until acked
- `req_mask`  in  NREQ*WIDTH  per-core pin mask; slice i = `[i*WIDTH +: WIDTH]`; 1 = pin updated
- `req_data`  in  NREQ*WIDTH  per-core write data, same slicing
- `req_lock`  in  NREQ  request/keep exclusive ownership after grant
- `ack`  out  NREQ  one-cycle pulse; write accepted and issued
- `gpio_dir`  out  WIDTH  to GPIO `dir`
- `gpio_wdata`  out  WIDTH  to GPIO `write_data`
- `gpio_we`  out  1  to GPIO `write_enable`
- `owner`  out  $clog2(NREQ)  index of last granted / locking requester
- `locked`  out  1  high while in LOCKED

## Operation
- FSM states: IDLE, ISSUE, LOCKED.
- **IDLE:**
  - If any `req` is high, pick the winner by round-robin. Search starts at `ptr` and wraps modulo NREQ.
  - Register the winner's mask/data into `gpio_dir`/`gpio_wdata` and set `owner`.
  - Go to ISSUE. Record `lock_pending = req_lock[winner]`.
- **ISSUE:**
  - `gpio_we` = 1 and `ack[owner]` = 1 for this single cycle.
  - `ptr` ← owner+1 (wraps to 0 after NREQ-1).
  - `req` is not sampled in this cycle, so a requester dropping `req` after ack is never double-served.
  - Next state is LOCKED if `lock_pending`, else IDLE.
- **LOCKED:**
  - Only `owner` is served. `req[owner]` high → latch its mask/data and go to ISSUE. `lock_pending` = current `req_lock[owner]`.
  - `req_lock[owner]` low with `req[owner]` low → IDLE.
  - Other requests wait; they are never dropped.
- `gpio_dir` and `gpio_wdata` hold their last values while `gpio_we` = 0. The GPIO ignores them then.
- A mask of all zeros is still issued and acked. It has no effect on the pins.
- Requester rules:
  - Keep `req`, mask, data and lock stable from assertion until `ack`.
  - Deassert `req` or present the next write in the cycle after `ack`.
- Reset (any state) → IDLE, `ptr`=0, `owner`=0, all outputs 0. A write in flight is lost: no `ack`, no `gpio_we` after reset is asserted.

## Timing
- Request sampled at edge t (state IDLE) → `gpio_we`/`ack` high during cycle t+1 → GPIO `gpio_out` updated at edge t+2.
- Maximum throughput is one write per 2 cycles, in IDLE→ISSUE or LOCKED→ISSUE loops.
- Worst-case wait for an unlocked requester is 2·(NREQ-1) cycles after its first sampled cycle, plus the duration of any active lock.
- `ack` is never high for more than one cycle. At most one `ack` bit is set per cycle. `gpio_we` equals the OR of `ack`.
- Simultaneous requests in the same cycle are resolved purely by `ptr`.

## Structure
- Shared package `gpio_arb_pkg`: state enum (IDLE/ISSUE/LOCKED), `OWNER_W = $clog2(NREQ)` helper function.
- One natural sub-module: `gpio_rr_pick`.
  - Combinational round-robin priority pick.
  - Inputs: `req` vector and `ptr`. Outputs: `valid` and winner `idx`.
  - Implemented by rotating `req` by `ptr`, taking the lowest-index set bit, and rotating back.
- Top level holds the FSM, `ptr`, `lock_pending` and the output registers.

## Test plan
- Single req[2]=1, mask=0x0000_00FF, data=0x0000_00A5 → `gpio_we`/`ack[2]` one cycle later, `gpio_dir`=0xFF, `gpio_wdata`=0xA5. GPIO low byte reads 0xA5 next edge.
- All four reqs asserted from reset, each held until its ack → acks in order 0,1,2,3 on cycles 1,3,5,7. `ptr` ends at 0.
- req[1] and req[3] continuously re-requested after ack → grants alternate 1,3,1,3. Neither waits more than 2 cycles between its ack and its next grant.
- req[0] with lock=1 for 3 writes while req[2] is pending → three consecutive acks to 0 with `locked`=1. After req_lock[0] drops, req[2] is acked within 2 cycles.
- rst asserted in the ISSUE cycle of a req[1] write → `gpio_we`, `ack`, `gpio_dir`, `gpio_wdata` go 0 immediately. After release, the pending req[1] is reissued from IDLE.
- req[3] with mask=0 → ack still pulsed, GPIO pins unchanged.
